fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the combinational instruction ROM.
- Owns the program counter (PC) and drives the ROM byte address.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for decode.
- Handles stall, redirect (branch/jump), and halt when the PC runs off the end of the ROM.

Parameters:
- IMEM_SIZE, 1024: ROM size in bytes; power of two, > 4.
- RESET_PC, 16'h0000: PC value loaded on reset; must be word-aligned.
- PC_STEP, 4: byte increment per sequential fetch. The ROM holds one 16-bit instruction per 4-byte slot.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register (hazard from decode/execute).
- redirect_valid  in  1  load new PC this cycle and flush IF/ID.
- redirect_pc  in  16  redirect target byte address.
- imem_address  out  16  byte address to ROM; equals the PC register.
- imem_instruction  in  16  combinational ROM read data for imem_address.
- id_valid  out  1  IF/ID register holds a real instruction.
- id_instruction  out  16  IF/ID instruction.
- id_pc  out  16  byte address id_instruction was fetched from.
- halted  out  1  fetch has stopped: PC is out of bounds.
- misalign_err  out  1  sticky flag: a misaligned redirect was received.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high, sampled at posedge clk.
- Reset values (override all other inputs):
  - pc = RESET_PC, state = WARM
  - id_valid = 0, id_instruction = 0, id_pc = 0
  - halted = 0, misalign_err = 0
- States:
  - WARM: one cycle after reset, no capture; id_valid stays 0.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- WARM -> RUN unconditionally on the next edge. PC is unchanged in WARM, so the first captured instruction is at RESET_PC.
- in_range = (pc + 3 < IMEM_SIZE), computed 17 bits wide with no wrap.
- Priority per edge: reset > redirect_valid > stall > sequential advance.
- RUN, redirect_valid=1:
  - pc <= {redirect_pc[15:2], 2'b00}
  - id_valid <= 0 (flush)
  - if redirect_pc[1:0] != 0, misalign_err <= 1
  - applies even when stall=1
- RUN, stall=1, no redirect: pc, id_* and state all hold.
- RUN, advance, in_range=1:
  - id_instruction <= imem_instruction, id_pc <= pc, id_valid <= 1
  - pc <= pc + PC_STEP (16-bit wrap; 16'hFFFC + 4 = 16'h0000)
- RUN, advance, in_range=0: id_valid <= 0, state <= HALT, pc holds.
- halted: registered; equals (state == HALT).
- HALT:
  - id_valid = 0; PC holds; stall ignored.
  - A redirect loads pc as in RUN, with the same alignment rule, and returns to RUN. The first new instruction is valid one edge later.
- Latency: instruction at address A appears on id_* one edge after imem_address = A.
- imem_address is always word-aligned, so the ROM alignment assertion never fires.
- Reset asserted mid-stall or mid-redirect: reset wins and the stage returns to WARM.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (edges with id_valid <= 1), perf_stalled[31:0] (RUN edges with stall and no redirect) and perf_flushed[31:0] (redirect edges).
  - All three clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {WARM, RUN, HALT}
  - localparams INSTR_W = 16, ADDR_W = 16, PC_STEP = 4
  - if_id_t struct {valid, instruction, pc}
- Sub-module pc_reg: PC register with next-PC mux (reset / redirect / stall / advance) and the alignment fix. The IF/ID register and state machine stay in fetch_stage.

Test Plan:
- Reset, then free run with ROM words 0x1111, 0x2222, 0x3333 at bytes 0, 4, 8:
  - id_valid is 0 on the first edge.
  - Then id_pc = 0, 4, 8 with id_instruction = 0x1111, 0x2222, 0x3333 on successive edges.
- stall=1 for 3 edges while id_pc = 4: id_* and imem_address = 8 hold.
  - After release, id_pc = 8, 0x3333.
- redirect_valid=1, redirect_pc = 0x0040 while stall=1:
  - Next edge id_valid = 0, imem_address = 0x0040.
  - Following edge id_pc = 0x0040.
- redirect_pc = 0x0042:
  - imem_address = 0x0040, misalign_err = 1.
  - misalign_err stays 1 until reset.
- IMEM_SIZE = 1024, run to pc = 0x03FC then 0x0400:
  - Last valid id_pc = 0x03FC; halted = 1, id_valid = 0.
  - A redirect to 0x0000 clears halted and resumes fetch.
- Assert reset for one edge mid-run:
  - All outputs take their reset values; the first valid id_pc after reset = RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and widths used by the fetch stage and its neighbours.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    WARM = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from decode/execute, ROM port and the IF/ID outputs.
// With FETCH_PERF_EN defined the bus also carries the three perf counters.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instruction;
  logic [ADDR_W-1:0]  id_pc;
  logic               halted;
  logic               misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_stalled;
  logic [31:0]        perf_flushed;
`endif

  // valid/ready note: there is no ready; id_valid marks a new or held
  // instruction, and the consumer applies back-pressure through stall.
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_instruction,
    output imem_address, id_valid, id_instruction, id_pc, halted, misalign_err
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_stalled, perf_flushed
`endif
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_instruction,
    input  imem_address, id_valid, id_instruction, id_pc, halted, misalign_err
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_stalled, perf_flushed
`endif
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC selection: reset, redirect (word-aligned), advance.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  // The low two bits are dropped so the ROM always sees a word-aligned address.
  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (advance)        pc <= pc + ADDR_W'(PC_STEP);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, WARM/RUN/HALT control and the IF/ID register.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                IMEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus,
  output fetch_state_t  state_dbg
);

  fetch_state_t      state, state_nx;
  if_id_t            if_id, if_id_nx;
  logic [ADDR_W-1:0] pc;
  logic              in_range;
  logic              redirect_take;
  logic              advance;
  logic              stall_hold;
  logic              halted_q;
  logic              misalign_q;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_take),
    .redirect_pc   (bus.redirect_pc),
    .advance       (advance),
    .pc            (pc)
  );

  // One extra bit so the bound test cannot wrap near the top of the address space.
  assign in_range = ({1'b0, pc} + (ADDR_W+1)'(3)) < (ADDR_W+1)'(IMEM_SIZE);

  always_comb begin
    state_nx      = state;
    if_id_nx      = if_id;
    redirect_take = 1'b0;
    advance       = 1'b0;
    stall_hold    = 1'b0;
    case (state)
      WARM: state_nx = RUN;
      RUN: begin
        if (bus.redirect_valid) begin
          redirect_take  = 1'b1;
          if_id_nx.valid = 1'b0;
        end else if (bus.stall) begin
          stall_hold = 1'b1;
        end else if (in_range) begin
          advance              = 1'b1;
          if_id_nx.valid       = 1'b1;
          if_id_nx.instruction = bus.imem_instruction;
          if_id_nx.pc          = pc;
        end else begin
          if_id_nx.valid = 1'b0;
          state_nx       = HALT;
        end
      end
      HALT: begin
        if_id_nx.valid = 1'b0;
        if (bus.redirect_valid) begin
          redirect_take = 1'b1;
          state_nx      = RUN;
        end
      end
      default: state_nx = WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WARM;
      if_id      <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state    <= state_nx;
      if_id    <= if_id_nx;
      halted_q <= (state_nx == HALT);
      if (redirect_take && (bus.redirect_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stalled_q, flushed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stalled_q <= '0;
      flushed_q <= '0;
    end else begin
      if (advance && (fetched_q != '1))       fetched_q <= fetched_q + 32'd1;
      if (stall_hold && (stalled_q != '1))    stalled_q <= stalled_q + 32'd1;
      if (redirect_take && (flushed_q != '1)) flushed_q <= flushed_q + 32'd1;
    end
  end

  assign bus.perf_fetched = fetched_q;
  assign bus.perf_stalled = stalled_q;
  assign bus.perf_flushed = flushed_q;
`endif

  assign bus.imem_address   = pc;
  assign bus.id_valid       = if_id.valid;
  assign bus.id_instruction = if_id.instruction;
  assign bus.id_pc          = if_id.pc;
  assign bus.halted         = halted_q;
  assign bus.misalign_err   = misalign_q;
  assign state_dbg          = state;

endmodule
